// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: control sequencer for the tiled multi-module matmul datapath.
//
// Walks every output tile of C in row-major order. Each tile is K inner blocks;
// each block is one ISSUE cycle (BRAM reads) followed by RUN (core enabled)
// until the core signals systolic_finish. After the last block the sequencer
// waits for the rising edge of acc_done, then presents the tile via
// out_valid/out_ready. All outputs are registered.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start_i               one-cycle run request, honoured only in IDLE or DONE
//   cfg_k_blocks_i        inner blocks per tile (K)
//   cfg_rows_i            C tile rows (R)
//   cfg_cols_i            C tile columns (C)
//   a_rd_en_o             input BRAM read enable, shared by all ports
//   a_rd_addr_o           packed input BRAM addresses, port p in slice p
//   b_rd_en_o             weight BRAM read enable
//   b_rd_addr_o           weight BRAM address
//   core_en_o             core enable
//   core_rst_n_o          core reset, active-low
//   acc_reset_o           accumulator clear, first block of each tile
//   systolic_finish_i     per-block completion from the core
//   acc_done_i            tile accumulation complete (level)
//   out_valid_o           finished tile available
//   out_ready_i           consumer accepts the tile
//   out_row_o, out_col_o  indices of the presented tile
//   busy_o                run in progress
//   done_o                run complete
//   cfg_err_o             last start carried a zero K, R or C
module matmul_tile_sequencer #(
    parameter int TOTAL_INPUT_W = 2,
    parameter int ADDR_WIDTH_A  = 16,
    parameter int ADDR_WIDTH_B  = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic [CNT_WIDTH-1:0]                  cfg_k_blocks_i,
    input  logic [CNT_WIDTH-1:0]                  cfg_rows_i,
    input  logic [CNT_WIDTH-1:0]                  cfg_cols_i,
    output logic                                  a_rd_en_o,
    output logic [TOTAL_INPUT_W*ADDR_WIDTH_A-1:0] a_rd_addr_o,
    output logic                                  b_rd_en_o,
    output logic [ADDR_WIDTH_B-1:0]               b_rd_addr_o,
    output logic                                  core_en_o,
    output logic                                  core_rst_n_o,
    output logic                                  acc_reset_o,
    input  logic                                  systolic_finish_i,
    input  logic                                  acc_done_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [CNT_WIDTH-1:0]                  out_row_o,
    output logic [CNT_WIDTH-1:0]                  out_col_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  cfg_err_o
);
    localparam int PW = 2 * CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, ISSUE, RUN, WAIT_ACC, OUTPUT, DONE} state_e;

    state_e                                state_q, state_d;
    logic [CNT_WIDTH-1:0]                  k_q, k_d, row_q, row_d, col_q, col_d;
    logic [CNT_WIDTH-1:0]                  kb_q, kb_d, rows_q, rows_d, cols_q, cols_d;
    logic                                  rd_en_q, rd_en_d;
    logic [TOTAL_INPUT_W*ADDR_WIDTH_A-1:0] a_addr_q, a_addr_d;
    logic [ADDR_WIDTH_B-1:0]               b_addr_q, b_addr_d;
    logic                                  core_en_q, core_en_d;
    logic                                  core_rst_n_q, core_rst_n_d;
    logic                                  acc_reset_q, acc_reset_d;
    logic                                  acc_done_q;
    logic                                  out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]                  out_row_q, out_row_d, out_col_q, out_col_d;
    logic                                  busy_q, busy_d, done_q, done_d;
    logic                                  cfg_err_q, cfg_err_d;
    logic                                  last_k, last_row, last_col, acc_rise, finish_now;

    assign last_k     = k_q == kb_q - ONE;
    assign last_row   = row_q == rows_q - ONE;
    assign last_col   = col_q == cols_q - ONE;
    // acc_done is a level; only its rising edge, seen while waiting, ends a tile.
    assign acc_rise   = acc_done_i && !acc_done_q;
    assign finish_now = state_q == RUN && systolic_finish_i;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        kb_d      = kb_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        cfg_err_d = cfg_err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    kb_d      = cfg_k_blocks_i;
                    rows_d    = cfg_rows_i;
                    cols_d    = cfg_cols_i;
                    k_d       = '0;
                    row_d     = '0;
                    col_d     = '0;
                    cfg_err_d = cfg_k_blocks_i == '0 || cfg_rows_i == '0 || cfg_cols_i == '0;
                    state_d   = cfg_err_d ? DONE : ISSUE;
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                if (systolic_finish_i) begin
                    k_d     = last_k ? '0 : k_q + ONE;
                    state_d = last_k ? WAIT_ACC : ISSUE;
                end
            end
            WAIT_ACC: state_d = acc_rise ? OUTPUT : WAIT_ACC;
            OUTPUT: begin
                if (out_ready_i) begin
                    col_d   = last_col ? '0 : col_q + ONE;
                    row_d   = last_col ? row_q + ONE : row_q;
                    state_d = (last_col && last_row) ? DONE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        busy_d      = state_d != IDLE && state_d != DONE;
        done_d      = state_d == DONE;
        rd_en_d     = state_d == ISSUE;
        core_en_d   = state_d == RUN;
        acc_reset_d = state_d == ISSUE && k_d == '0;
        // Core is out of reset for the whole run except one cycle after each
        // finished block; that pulse overlaps the next ISSUE, while the BRAM
        // read is still in flight.
        core_rst_n_d = busy_d && !finish_now;
        out_valid_d  = state_d == OUTPUT;
        out_row_d    = state_d == OUTPUT ? row_d : out_row_q;
        out_col_d    = state_d == OUTPUT ? col_d : out_col_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        if (state_d == ISSUE) begin
            for (int p = 0; p < TOTAL_INPUT_W; p++)
                a_addr_d[p*ADDR_WIDTH_A +: ADDR_WIDTH_A] = ADDR_WIDTH_A'(
                    (PW'(row_d) * PW'(TOTAL_INPUT_W) + PW'(p)) * PW'(kb_d) + PW'(k_d));
            b_addr_d = ADDR_WIDTH_B'(PW'(col_d) * PW'(kb_d) + PW'(k_d));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            kb_q         <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            rd_en_q      <= 1'b0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            acc_reset_q  <= 1'b0;
            acc_done_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            row_q        <= row_d;
            col_q        <= col_d;
            kb_q         <= kb_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            rd_en_q      <= rd_en_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            core_en_q    <= core_en_d;
            core_rst_n_q <= core_rst_n_d;
            acc_reset_q  <= acc_reset_d;
            acc_done_q   <= acc_done_i;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign a_rd_en_o    = rd_en_q;
    assign b_rd_en_o    = rd_en_q;
    assign a_rd_addr_o  = a_addr_q;
    assign b_rd_addr_o  = b_addr_q;
    assign core_en_o    = core_en_q;
    assign core_rst_n_o = core_rst_n_q;
    assign acc_reset_o  = acc_reset_q;
    assign out_valid_o  = out_valid_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cfg_err_o    = cfg_err_q;
endmodule
